mod_counter: RTL and testbench

MOD_COUNTER -- requirements
Module: mod_counter

---
 rtl/counter_pkg.sv | 14 +
 rtl/d_register.sv | 34 +++
 rtl/mod_counter.sv | 81 ++++++++
 tb/tb_mod_counter.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
//   Shared constants for the modulo counter block.
//   DEFAULT_WIDTH : default counter / data width in bits
//   DIR_UP/DOWN   : encodings of the UP direction input
// -----------------------------------------------------------------------------
package counter_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage : counter_pkg

// File: rtl/d_register.sv
// -----------------------------------------------------------------------------
// d_register
//   WIDTH-bit bank of D flip-flops with synchronous active-high reset.
//   Ports:
//     CLK   - rising-edge clock
//     RST   - synchronous active-high reset, clears the bank to zero
//     D     - next-state value
//     Q     - registered value
//     Q_neg - bitwise complement of Q (combinational off the flops)
// -----------------------------------------------------------------------------
module d_register
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_neg
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge CLK) begin
    if (RST) q_q <= '0;
    else     q_q <= D;
  end

  assign Q     = q_q;
  // Derived from the same flops so it never lags Q by a cycle.
  assign Q_neg = ~q_q;

endmodule : d_register

// File: rtl/mod_counter.sv
// -----------------------------------------------------------------------------
// mod_counter
//   Up/down counter with runtime modulus (sequence 0..MAX), parallel load with
//   clamping, combinational terminal count and a registered wrap pulse.
//   Ports:
//     CLK   - rising-edge clock
//     RST   - synchronous active-high reset (Q=0, WRAP=0)
//     EN    - count enable
//     LOAD  - parallel load strobe, overrides EN/UP
//     UP    - direction, 1 = up, 0 = down
//     D     - parallel load value (clamped to MAX)
//     MAX   - terminal value
//     Q     - registered count
//     Q_neg - ~Q
//     TC    - terminal count (combinational)
//     WRAP  - one-cycle pulse after an edge where TC was high
//   Priority: RST > LOAD > EN > hold.
// -----------------------------------------------------------------------------
module mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             LOAD,
  input  logic             UP,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] MAX,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_neg,
  output logic             TC,
  output logic             WRAP
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] up_val;
  logic [WIDTH-1:0] dn_val;
  logic             at_top;
  logic             at_bot;
  logic             wrap_q;

  // Q >= MAX (not ==) so a count left above a lowered MAX wraps to 0
  // instead of running on up to the natural WIDTH rollover.
  assign at_top = (cnt_q >= MAX);
  assign at_bot = (cnt_q == '0);

  assign load_val = (D > MAX) ? MAX : D;
  assign up_val   = at_top ? '0 : cnt_q + 1'b1;
  // Down from an out-of-range value re-enters the sequence at MAX.
  assign dn_val   = (at_bot || (cnt_q > MAX)) ? MAX : cnt_q - 1'b1;

  always_comb begin
    cnt_d = cnt_q;
    if (LOAD)    cnt_d = load_val;
    else if (EN) cnt_d = (UP == DIR_UP) ? up_val : dn_val;
  end

  assign TC = EN & ~LOAD & ((UP == DIR_UP) ? at_top : at_bot);

  d_register #(.WIDTH(WIDTH)) u_state (
    .CLK   (CLK),
    .RST   (RST),
    .D     (cnt_d),
    .Q     (cnt_q),
    .Q_neg (Q_neg)
  );

  // TC is already low on LOAD edges, so only reset needs explicit clearing.
  always_ff @(posedge CLK) begin
    if (RST) wrap_q <= 1'b0;
    else     wrap_q <= TC;
  end

  assign Q    = cnt_q;
  assign WRAP = wrap_q;

endmodule : mod_counter

// File: tb/tb_mod_counter.sv
module tb_mod_counter;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST, EN, LOAD, UP;
  logic [W-1:0] D, MAX;
  logic [W-1:0] Q, Q_neg;
  logic         TC, WRAP;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] q;
    logic         wrap;
    string        tag;
  } exp_t;

  exp_t sbq[$];

  // reference state
  logic [W-1:0] mq;
  bit           mvalid = 0;

  always #5 CLK = ~CLK;

  mod_counter #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .LOAD(LOAD), .UP(UP),
    .D(D), .MAX(MAX), .Q(Q), .Q_neg(Q_neg), .TC(TC), .WRAP(WRAP)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: check TC before the edge, push the expected
  // post-edge state, then pop and compare after the edge.
  task automatic step(input logic rst, input logic en, input logic load,
                      input logic up, input logic [W-1:0] d,
                      input logic [W-1:0] mx, input string tag);
    exp_t e;
    logic tc_exp;
    logic [W-1:0] nq;
    RST = rst; EN = en; LOAD = load; UP = up; D = d; MAX = mx;
    #1;
    tc_exp = 1'b0;
    if (mvalid) begin
      if (en && !load) tc_exp = up ? (mq >= mx) : (mq == 0);
      chk({tag, ".tc"}, {15'd0, TC}, {15'd0, tc_exp});
    end
    if (rst)       nq = '0;
    else if (load) nq = (d <= mx) ? d : mx;
    else if (!en)  nq = mq;
    else if (up)   nq = (mq < mx) ? mq + 8'd1 : 8'd0;
    else           nq = (mq != 0 && mq <= mx) ? mq - 8'd1 : mx;
    e.q    = nq;
    e.wrap = rst ? 1'b0 : tc_exp;
    e.tag  = tag;
    sbq.push_back(e);
    @(posedge CLK);
    #1;
    if (sbq.size() == 0) begin
      chk({tag, ".sb_empty"}, 16'd1, 16'd0);
    end else begin
      e = sbq.pop_front();
      chk({e.tag, ".q"},    {8'd0, Q},     {8'd0, e.q});
      chk({e.tag, ".qneg"}, {8'd0, Q_neg}, {8'd0, ~e.q});
      chk({e.tag, ".wrap"}, {15'd0, WRAP}, {15'd0, e.wrap});
    end
    mq = nq;
    mvalid = 1;
  endtask

  initial begin
    RST = 1'b0; EN = 1'b0; LOAD = 1'b0; UP = 1'b1; D = '0; MAX = 8'd9;
    @(posedge CLK); #1;

    // reset with EN and LOAD high
    step(1, 1, 1, 1, 8'h55, 8'd9, "rst0");
    step(1, 1, 1, 1, 8'h55, 8'd9, "rst1");
    chk("rst.q_const",    {8'd0, Q},     16'h0000);
    chk("rst.qneg_const", {8'd0, Q_neg}, 16'h00FF);
    chk("rst.wrap_const", {15'd0, WRAP}, 16'h0000);

    // count up modulo 10 for 12 cycles
    for (int i = 0; i < 12; i++) begin
      step(0, 1, 0, 1, 8'h00, 8'd9, "up9");
      chk("up9.q_const", {8'd0, Q}, 16'((i + 1) % 10));
      chk("up9.wrap_const", {15'd0, WRAP}, (i == 9) ? 16'd1 : 16'd0);
    end

    // count down from 0
    step(1, 0, 0, 1, 8'h00, 8'd9, "rst_dn");
    step(0, 1, 0, 0, 8'h00, 8'd9, "dn_wrap");
    chk("dn_wrap.q_const", {8'd0, Q}, 16'd9);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 8'h00, 8'd9, "dn");

    // load clamping
    step(0, 1, 1, 1, 8'h20, 8'd9, "ld_clamp");
    chk("ld_clamp.q_const", {8'd0, Q}, 16'd9);
    step(0, 1, 1, 1, 8'h05, 8'd9, "ld5");
    chk("ld5.q_const", {8'd0, Q}, 16'd5);

    // MAX lowered below Q
    step(0, 0, 1, 1, 8'h07, 8'd9, "ld7a");
    step(0, 1, 0, 1, 8'h00, 8'd3, "max_lo_up");
    chk("max_lo_up.q_const", {8'd0, Q}, 16'd0);
    step(0, 0, 1, 1, 8'h07, 8'd9, "ld7b");
    step(0, 1, 0, 0, 8'h00, 8'd3, "max_lo_dn");
    chk("max_lo_dn.q_const", {8'd0, Q}, 16'd3);
    step(0, 0, 1, 1, 8'h07, 8'd9, "ld7c");
    step(0, 0, 0, 1, 8'h00, 8'd3, "hold_hi");
    step(0, 0, 0, 0, 8'h00, 8'd3, "hold_hi2");

    // reset mid-count
    step(0, 0, 1, 1, 8'h03, 8'd9, "ld3");
    step(0, 1, 0, 1, 8'h00, 8'd9, "to4");
    step(1, 1, 0, 1, 8'h00, 8'd9, "rst_mid");
    step(0, 1, 0, 1, 8'h00, 8'd9, "post_rst");
    chk("post_rst.q_const", {8'd0, Q}, 16'd1);

    // MAX == 0
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 8'h00, 8'd0, "max0_up");
    for (int i = 0; i < 2; i++) step(0, 1, 0, 0, 8'h00, 8'd0, "max0_dn");

    // full-width rollover, direction flip with no turnaround
    step(0, 0, 1, 1, 8'hFE, 8'hFF, "ldFE");
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 8'h00, 8'hFF, "upFF");
    step(0, 1, 0, 0, 8'h00, 8'hFF, "flip_dn");
    step(0, 1, 0, 0, 8'h00, 8'hFF, "dnFF");

    // random mix
    for (int i = 0; i < 300; i++) begin
      logic [W-1:0] rmx;
      rmx = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
      step(($urandom_range(0, 30) == 0), 1'($urandom), ($urandom_range(0, 7) == 0),
           1'($urandom), 8'($urandom_range(0, 20)), rmx, "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule : tb_mod_counter
